aes_inv_round_ctrl: RTL and testbench

Sequencer for the AES inverse cipher datapath. It steps the stage blocks AddRoundKey, InvShiftRows, InvSubBytes and InvMixColumns through the full decryption schedule using per-stage enable/valid handshakes. It also drives the round-key index toward the key store. It sits between the top-level decrypt request interface and the stage blocks, and holds no state data itself.

---
 rtl/aes_inv_round_ctrl_if.sv | 27 ++
 rtl/aes_inv_round_ctrl.sv | 108 ++++++++++
 tb/tb_aes_inv_round_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_round_ctrl_if.sv
// Decrypt request and stage enable/valid handshake bundle for the AES inverse round sequencer.
interface aes_inv_round_ctrl_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] round;
  logic [3:0] key_idx;
  logic       ark_en;
  logic       ark_valid;
  logic       isr_en;
  logic       isr_valid;
  logic       isb_en;
  logic       isb_valid;
  logic       imc_en;
  logic       imc_valid;

  modport master (
    input  start, ark_valid, isr_valid, isb_valid, imc_valid,
    output busy, done, error, round, key_idx, ark_en, isr_en, isb_en, imc_en
  );

  modport slave (
    output start, ark_valid, isr_valid, isb_valid, imc_valid,
    input  busy, done, error, round, key_idx, ark_en, isr_en, isb_en, imc_en
  );
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// Sequencer stepping AddRoundKey/InvShiftRows/InvSubBytes/InvMixColumns through the
// AES decryption schedule, with per-stage enable/valid handshakes and stage timeout.
module aes_inv_round_ctrl #(
  parameter int unsigned NR      = 10,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_inv_round_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, ARK0, ISR, ISB, ARK, IMC, FIN} state_t;

  localparam logic [3:0] NR_L    = 4'(NR);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] round_q, round_nxt;
  logic [3:0] key_q, key_nxt;
  logic       err_q, err_nxt;
  logic       stage_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      round_q <= '0;
      key_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      round_q <= round_nxt;
      key_q   <= key_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    stage_valid = 1'b0;
    case (state)
      ARK0, ARK: stage_valid = bus.ark_valid;
      ISR:       stage_valid = bus.isr_valid;
      ISB:       stage_valid = bus.isb_valid;
      IMC:       stage_valid = bus.imc_valid;
      default:   stage_valid = 1'b0;
    endcase
  end

  // cnt==0 marks the enable cycle of a stage; valid is only honoured after it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    round_nxt = round_q;
    key_nxt   = key_q;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        // err_q high means this is the error cycle: start is not accepted yet
        if (bus.start && !err_q) begin
          state_nxt = ARK0;
          round_nxt = NR_L;
          key_nxt   = NR_L;
          cnt_nxt   = '0;
        end
      end
      FIN: state_nxt = IDLE;
      default: begin
        if (cnt == '0) begin
          cnt_nxt = 8'd1;
        end else if (stage_valid) begin
          cnt_nxt = '0;
          case (state)
            ARK0, IMC: begin
              state_nxt = ISR;
              round_nxt = round_q - 4'd1;
            end
            ISR:     state_nxt = ISB;
            ISB: begin
              state_nxt = ARK;
              key_nxt   = round_q;
            end
            ARK:     state_nxt = (round_q == '0) ? FIN : IMC;
            default: state_nxt = IDLE;
          endcase
        end else if (cnt == TO_LAST) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
    endcase
  end

  assign bus.busy    = (state != IDLE) && (state != FIN);
  assign bus.done    = (state == FIN);
  assign bus.error   = err_q;
  assign bus.round   = round_q;
  assign bus.key_idx = key_q;
  assign bus.ark_en  = ((state == ARK0) || (state == ARK)) && (cnt == '0);
  assign bus.isr_en  = (state == ISR) && (cnt == '0);
  assign bus.isb_en  = (state == ISB) && (cnt == '0);
  assign bus.imc_en  = (state == IMC) && (cnt == '0);

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Scoreboard bench for aes_inv_round_ctrl: NR=10 and NR=14 instances, randomized stage latencies.
module tb_aes_inv_round_ctrl;
  localparam int TO = 16;
  localparam int K_ARK = 0, K_ISR = 1, K_ISB = 2, K_IMC = 3, K_DONE = 4, K_ERR = 5;

  typedef struct {
    int kind;
    int rnd;
    int key;
    bit first;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b0;
  logic start = 1'b0;
  logic ark_valid = 1'b0, isr_valid = 1'b0, isb_valid = 1'b0, imc_valid = 1'b0;

  logic       o_busy, o_done, o_error, o_ark_en, o_isr_en, o_isb_en, o_imc_en;
  logic [3:0] o_round, o_key;

  int   cyc = 0;
  int   base = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_valid_rel = 0;
  int   last_en_rel = 0;
  int   n_isr = 0, n_imc = 0;
  int   hold_kind = -1, hold_round = -1, spur_round = -1, exp_done_rel = 0;
  bit   rand_delay = 1'b0;
  bit   seen_ark6 = 1'b0;
  exp_t sb[$];

  aes_inv_round_ctrl_if if10 ();
  aes_inv_round_ctrl_if if14 ();

  assign if10.start = start && !sel;
  assign if14.start = start && sel;
  assign if10.ark_valid = ark_valid;
  assign if10.isr_valid = isr_valid;
  assign if10.isb_valid = isb_valid;
  assign if10.imc_valid = imc_valid;
  assign if14.ark_valid = ark_valid;
  assign if14.isr_valid = isr_valid;
  assign if14.isb_valid = isb_valid;
  assign if14.imc_valid = imc_valid;

  aes_inv_round_ctrl #(.NR(10), .TIMEOUT(TO)) dut10 (.clk(clk), .rst(rst), .bus(if10));
  aes_inv_round_ctrl #(.NR(14), .TIMEOUT(TO)) dut14 (.clk(clk), .rst(rst), .bus(if14));

  always_comb begin
    o_busy   = sel ? if14.busy    : if10.busy;
    o_done   = sel ? if14.done    : if10.done;
    o_error  = sel ? if14.error   : if10.error;
    o_round  = sel ? if14.round   : if10.round;
    o_key    = sel ? if14.key_idx : if10.key_idx;
    o_ark_en = sel ? if14.ark_en  : if10.ark_en;
    o_isr_en = sel ? if14.isr_en  : if10.isr_en;
    o_isb_en = sel ? if14.isb_en  : if10.isb_en;
    o_imc_en = sel ? if14.imc_en  : if10.imc_en;
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc - base + 1);
    end
  endtask

  // Reference schedule: ARK0, then per round ISR/ISB/ARK(/IMC), then done.
  function automatic bit add(input int k, input int r, input int hk, input int hr, input bit first);
    sb.push_back('{k, r, r, first});
    if (k == hk && r == hr) begin
      sb.push_back('{K_ERR, 0, 0, 1'b0});
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void build(input int nr, input int hk, input int hr);
    sb.delete();
    if (add(K_ARK, nr, hk, hr, 1'b1)) return;
    for (int r = nr - 1; r >= 0; r--) begin
      if (add(K_ISR, r, hk, hr, 1'b0)) return;
      if (add(K_ISB, r, hk, hr, 1'b0)) return;
      if (add(K_ARK, r, hk, hr, 1'b0)) return;
      if (r > 0 && add(K_IMC, r, hk, hr, 1'b0)) return;
    end
    sb.push_back('{K_DONE, 0, 0, 1'b0});
  endfunction

  task automatic take(input string name, input int kind, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{-1, 0, 0, 1'b0};
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got event kind %0d, expected nothing (cycle %0d)", name, kind, cyc - base + 1);
    end else begin
      e  = sb.pop_front();
      ok = 1'b1;
      chk(name, kind, e.kind);
    end
  endtask

  // Monitor: compares every presented enable/done/error against the scoreboard
  initial begin : monitor
    exp_t e;
    bit   ok;
    int   rel, k;
    forever begin
      @(negedge clk);
      rel = cyc - base + 1;
      if (rst) begin
        if (o_ark_en || o_isr_en || o_isb_en || o_imc_en) begin
          chk("en_onehot", $countones({o_ark_en, o_isr_en, o_isb_en, o_imc_en}), 1);
          k = o_ark_en ? K_ARK : o_isr_en ? K_ISR : o_isb_en ? K_ISB : K_IMC;
          take("stage_kind", k, e, ok);
          if (ok) begin
            chk("stage_round", int'(o_round), e.rnd);
            if (k == K_ARK) chk("key_idx", int'(o_key), e.key);
            chk("en_timing", rel, e.first ? 1 : last_valid_rel + 1);
            chk("busy_in_stage", int'(o_busy), 1);
          end
          last_en_rel = rel;
          if (k == K_ISR) n_isr++;
          if (k == K_IMC) n_imc++;
          if (k == K_ARK && o_round == 4'd6) seen_ark6 = 1'b1;
        end
        if (o_done) begin
          chk("done_error_excl", int'(o_error), 0);
          take("done_event", K_DONE, e, ok);
          chk("done_timing", rel, last_valid_rel + 1);
          chk("busy_at_done", int'(o_busy), 0);
          if (exp_done_rel > 0) chk("done_cycle", rel, exp_done_rel);
        end
        if (o_error) begin
          take("error_event", K_ERR, e, ok);
          chk("error_timing", rel, last_en_rel + TO);
          chk("busy_at_error", int'(o_busy), 0);
        end
      end
    end
  end

  // Stage responder: returns each stage's valid after a delay, with optional faults
  initial begin : responder
    int k, r, d;
    forever begin
      @(negedge clk);
      if (rst && (o_ark_en || o_isr_en || o_isb_en || o_imc_en)) begin
        k = o_ark_en ? K_ARK : o_isr_en ? K_ISR : o_isb_en ? K_ISB : K_IMC;
        r = int'(o_round);
        if (!(k == hold_kind && r == hold_round)) begin
          d = rand_delay ? int'($urandom_range(1, 5)) : 1;
          if (k == K_ISR && r == spur_round) begin
            isr_valid = 1'b1;
            @(posedge clk); #1;
            isr_valid = 1'b0;
            imc_valid = 1'b1;
            @(posedge clk); #1;
            imc_valid = 1'b0;
            d = 1;
          end
          repeat (d) @(posedge clk);
          #1;
          case (k)
            K_ARK:   ark_valid = 1'b1;
            K_ISR:   isr_valid = 1'b1;
            K_ISB:   isb_valid = 1'b1;
            default: imc_valid = 1'b1;
          endcase
          last_valid_rel = cyc - base + 1;
          @(posedge clk); #1;
          ark_valid = 1'b0;
          isr_valid = 1'b0;
          isb_valid = 1'b0;
          imc_valid = 1'b0;
        end
      end
    end
  end

  task automatic run(input bit s, input bit rnd, input int hk, input int hr, input int spr,
                     input int done_rel, input bit poke);
    int nr;
    nr = s ? 14 : 10;
    sel = s;
    rand_delay = rnd;
    hold_kind = hk;
    hold_round = hr;
    spur_round = spr;
    exp_done_rel = done_rel;
    n_isr = 0;
    n_imc = 0;
    build(nr, hk, hr);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = cyc;
    if (poke) begin
      repeat (19) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
    chk("schedule_complete", sb.size(), 0);
    if (hk < 0) begin
      chk("isr_count", n_isr, nr);
      chk("imc_count", n_imc, nr - 1);
    end
    repeat (3) @(negedge clk);
    chk("idle_after_run", int'(o_busy), 0);
    hold_kind = -1;
    hold_round = -1;
    spur_round = -1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin : stimulus
    #1;
    chk("reset_outputs", int'({if10.busy, if10.done, if10.error, if10.round, if10.key_idx,
        if10.ark_en, if10.isr_en, if10.isb_en, if10.imc_en}), 0);
    #20 rst = 1'b1;
    repeat (2) @(posedge clk);

    run(1'b0, 1'b0, -1, -1, -1, 81, 1'b0);     // NR=10 unit latency, done at 81
    run(1'b1, 1'b1, -1, -1, -1, 0, 1'b0);      // NR=14 random latency
    run(1'b0, 1'b1, K_ISB, 5, -1, 0, 1'b0);    // withheld isb_valid -> timeout
    run(1'b0, 1'b1, -1, -1, -1, 0, 1'b0);      // clean run after error
    run(1'b0, 1'b0, -1, -1, 7, 0, 1'b0);       // spurious/early valids ignored
    run(1'b0, 1'b0, -1, -1, -1, 81, 1'b1);     // start during run ignored

    // Asynchronous reset in the middle of the round-6 AddRoundKey
    sel = 1'b0;
    rand_delay = 1'b1;
    seen_ark6 = 1'b0;
    build(10, -1, -1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    base = cyc;
    for (int i = 0; i < 2000 && !seen_ark6; i++) @(posedge clk);
    chk("reached_ark6", int'(seen_ark6), 1);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", int'({o_busy, o_done, o_error, o_round, o_key,
        o_ark_en, o_isr_en, o_isb_en, o_imc_en}), 0);
    sb.delete();
    #4 rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("idle_after_reset", int'(o_busy), 0);

    run(1'b0, 1'b1, -1, -1, -1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
